mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the fetch stage and the memory stage of the datapath.
- Grants one transaction at a time to one of the two requesters.
- Tracks the fixed memory latency and returns the response to the owning requester.
- Gives data-side priority with starvation protection for fetch, and drops fetch responses on a pipeline flush (branch redirect).

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data word width
MEM_LATENCY, 2, cycles from mem_en to valid mem_rdata; legal range is 1 to 7
STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced to win

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr until if_gnt
if_addr  in  ADDR_W  fetch address
if_flush  in  1  drop any in-flight fetch; mask if_req this cycle
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid, one-cycle pulse
if_rdata  out  DATA_W  fetch data
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata/dm_be until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_be  in  DATA_W/8  store byte enables
dm_gnt  out  1  data request accepted this cycle
dm_rvalid  out  1  load data valid or store complete, one-cycle pulse
dm_rdata  out  DATA_W  load data; 0 for stores
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables (all ones for fetch)
mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en
busy  out  1  a transaction is in flight

Behaviour:

State machine:
- States: IDLE and WAIT.
- Registered state: owner (NONE/IF/DM), down-counter lat_cnt, starve_cnt, flush_pend.

Granting:
- A grant is possible in IDLE, or in WAIT on the completion cycle (lat_cnt==1).
- On a grant cycle, if_gnt/dm_gnt, mem_en and mem_* are combinational from the inputs, so the request is issued the same cycle.
- Next state is WAIT, with lat_cnt=MEM_LATENCY and owner set to the winner.

Arbitration:
- Effective fetch request = if_req & ~if_flush.
- When both request, DM wins unless starve_cnt==STARVE_MAX, in which case IF wins.
- starve_cnt increments on each DM grant while the effective fetch request is high.
- starve_cnt clears on an IF grant or when if_req is low; it saturates at STARVE_MAX.

Completion:
- lat_cnt decrements every cycle in WAIT.
- At lat_cnt==1, the owner's rvalid pulses and rdata = mem_rdata (dm_rdata = 0 for stores).
- If no new grant occurs that cycle, the state returns to IDLE.
- Throughput: one transaction per MEM_LATENCY cycles; back-to-back issue happens in the same cycle as the previous rvalid.

Flush:
- if_flush while owner==IF and in WAIT sets flush_pend.
- if_rvalid is suppressed at completion. The memory timing still completes, and the port is not freed early.
- if_flush on the completion cycle itself also suppresses if_rvalid.
- flush_pend clears when the transaction completes.
- DM transactions are unaffected by flush.

Idle defaults:
- mem_* = 0 and rdata = 0 whenever not issuing or responding.
- Gnt and rvalid are never asserted together for different owners except at a back-to-back handoff: the old owner's rvalid plus the new grant.

Reset:
- Asynchronous reset forces IDLE, owner=NONE, all counters 0, and all outputs 0; the combinational outputs are gated by rst_n.
- An in-flight transaction is abandoned; no rvalid is produced after reset release.

Decomposition:
- Package mem_arb_pkg holds the owner enum (OWN_NONE, OWN_IF, OWN_DM) and width localparams: LAT_W = 3 and the byte-enable width.
- One sub-module, mem_arb_prio, contains the two-requester priority select and the saturating starve_cnt. It outputs a winner and is reused for future ports.

Test Plan:
1. Single load: dm_req, addr 0x40, MEM_LATENCY=2 -> dm_gnt and mem_en in cycle t; dm_rvalid at t+2 with dm_rdata = mem_rdata (0xDEADBEEF); if_rvalid stays 0.
2. Simultaneous requests, if_req held high with dm_req held for 6 transactions, STARVE_MAX=4 -> grant order DM,DM,DM,DM,IF,DM; each grant is back-to-back with the previous rvalid.
3. Fetch flush: IF granted at t, if_flush at t+1 -> no if_rvalid at t+2; a DM request pending at t+2 is granted at t+2.
4. Store: dm_we=1, dm_be=4'b0011, wdata 0x1234 -> mem_we=1, mem_be=0011 at the grant; dm_rvalid at t+2 with dm_rdata=0.
5. Reset mid-op: assert rst_n=0 at t+1 of a fetch -> all outputs 0 immediately; after release, no if_rvalid; busy=0 until the next request.
6. MEM_LATENCY=1 instance: alternating IF/DM requests -> one grant and one rvalid every cycle, and each response routes to the correct owner.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and width constants for the unified memory port arbiter.
package mem_arb_pkg;

   // Width of the memory latency down-counter (latency range 1..7).
   localparam int LAT_W = 3;

   // Byte-enable width for the default 32-bit data word.
   localparam int BE_W = 4;

   // Which requester currently owns the memory port.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_t;

   // Arbiter control state, also exported for debug.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } arb_state_t;

   // Byte-enable width for an arbitrary data width.
   function automatic int be_width(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of the port arbiter.
//
// Handshake: a requester raises *_req with its payload and holds both
// unchanged until it sees *_gnt high in the same cycle; gnt is the accept
// and the transfer happens in that cycle. *_rvalid is a single-cycle pulse
// with no backpressure. mem_en is a one-cycle strobe, and mem_rdata must be
// valid exactly MEM_LATENCY cycles later.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BW = be_width(DATA_W);

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic [BW-1:0]     dm_be;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [BW-1:0]     mem_be;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side: serves both requesters and drives the memory.
   modport slave (
      input  if_req, if_addr, if_flush,
      output if_gnt, if_rvalid, if_rdata,
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      output dm_gnt, dm_rvalid, dm_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_rdata
   );

   // Requester and memory side.
   modport master (
      output if_req, if_addr, if_flush,
      input  if_gnt, if_rvalid, if_rdata,
      output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      input  dm_gnt, dm_rvalid, dm_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_rdata
   );

endinterface

// File: rtl/mem_arb_prio.sv
// Two-requester priority select: the high-priority side wins a tie unless
// the low-priority side has been passed over STARVE_MAX times in a row.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   grant_en,   // a grant may be issued this cycle
   input  logic   hi_req,     // high-priority request (data side)
   input  logic   lo_req,     // effective low-priority request (fetch side)
   input  logic   lo_hold,    // raw low-priority request; low clears the count
   output owner_t winner
);

   localparam int SC_W = $clog2(STARVE_MAX + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

   logic [SC_W-1:0] starve_cnt;
   logic            starved;

   assign starved = (starve_cnt == SC_MAX);

   // Pick the winner among the current requests.
   always_comb begin
      winner = OWN_NONE;
      if (grant_en) begin
         if (hi_req && lo_req) begin
            winner = starved ? OWN_IF : OWN_DM;
         end else if (hi_req) begin
            winner = OWN_DM;
         end else if (lo_req) begin
            winner = OWN_IF;
         end
      end
   end

   // Count consecutive high-side wins while the low side waits; saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (!lo_hold || (winner == OWN_IF)) begin
         starve_cnt <= '0;
      end else if ((winner == OWN_DM) && lo_req && !starved) begin
         starve_cnt <= starve_cnt + SC_W'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch and data requesters.
// One transaction is in flight at a time; a new grant may overlap the
// completion cycle of the previous one so throughput is one access per
// MEM_LATENCY cycles.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 2,
   parameter int STARVE_MAX  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   mem_port_arbiter_if.slave bus,
   output logic       busy,
   output arb_state_t state_dbg
);

   localparam int BW = be_width(DATA_W);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY);
   localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

   arb_state_t        state_q, state_d;
   owner_t            owner_q, owner_d;
   owner_t            winner;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic              flush_q, flush_d;
   logic              we_q, we_d;

   logic              complete;
   logic              grant_en;
   logic              eff_if;

   logic              if_gnt_c, if_rvalid_c, dm_gnt_c, dm_rvalid_c;
   logic [DATA_W-1:0] if_rdata_c, dm_rdata_c;
   logic              mem_en_c, mem_we_c;
   logic [ADDR_W-1:0] mem_addr_c;
   logic [DATA_W-1:0] mem_wdata_c;
   logic [BW-1:0]     mem_be_c;

   // The last cycle of the in-flight access; it is also a grant slot.
   assign complete = (state_q == ST_WAIT) && (lat_q == LAT_ONE);
   assign grant_en = rst_n && ((state_q == ST_IDLE) || complete);
   // A flush masks the fetch request in the cycle it is raised.
   assign eff_if   = bus.if_req && !bus.if_flush;

   mem_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .clk      (clk),
      .rst_n    (rst_n),
      .grant_en (grant_en),
      .hi_req   (bus.dm_req),
      .lo_req   (eff_if),
      .lo_hold  (bus.if_req),
      .winner   (winner)
   );

   // Control state register; reset abandons any in-flight access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_NONE;
         lat_q   <= '0;
         flush_q <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         lat_q   <= lat_d;
         flush_q <= flush_d;
         we_q    <= we_d;
      end
   end

   // Next state, memory issue and response routing.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      lat_d       = lat_q;
      flush_d     = flush_q;
      we_d        = we_q;
      if_gnt_c    = 1'b0;
      if_rvalid_c = 1'b0;
      if_rdata_c  = '0;
      dm_gnt_c    = 1'b0;
      dm_rvalid_c = 1'b0;
      dm_rdata_c  = '0;
      mem_en_c    = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      mem_be_c    = '0;

      // Issue the winning request to memory in the same cycle.
      if (winner == OWN_DM) begin
         dm_gnt_c    = 1'b1;
         mem_en_c    = 1'b1;
         mem_we_c    = bus.dm_we;
         mem_addr_c  = bus.dm_addr;
         mem_wdata_c = bus.dm_wdata;
         mem_be_c    = bus.dm_be;
      end else if (winner == OWN_IF) begin
         if_gnt_c    = 1'b1;
         mem_en_c    = 1'b1;
         mem_addr_c  = bus.if_addr;
         mem_be_c    = '1;
      end

      // Return the response to the owner; a flushed fetch is dropped.
      if (complete && rst_n) begin
         if (owner_q == OWN_IF) begin
            if (!flush_q && !bus.if_flush) begin
               if_rvalid_c = 1'b1;
               if_rdata_c  = bus.mem_rdata;
            end
         end else if (owner_q == OWN_DM) begin
            dm_rvalid_c = 1'b1;
            dm_rdata_c  = we_q ? '0 : bus.mem_rdata;
         end
      end

      if (winner != OWN_NONE) begin
         state_d = ST_WAIT;
         owner_d = winner;
         lat_d   = LAT_INIT;
         flush_d = 1'b0;
         we_d    = (winner == OWN_DM) && bus.dm_we;
      end else if (complete) begin
         state_d = ST_IDLE;
         owner_d = OWN_NONE;
         lat_d   = '0;
         flush_d = 1'b0;
         we_d    = 1'b0;
      end else if (state_q == ST_WAIT) begin
         lat_d = lat_q - LAT_ONE;
         if ((owner_q == OWN_IF) && bus.if_flush) begin
            flush_d = 1'b1;
         end
      end
   end

   assign bus.if_gnt    = if_gnt_c;
   assign bus.if_rvalid = if_rvalid_c;
   assign bus.if_rdata  = if_rdata_c;
   assign bus.dm_gnt    = dm_gnt_c;
   assign bus.dm_rvalid = dm_rvalid_c;
   assign bus.dm_rdata  = dm_rdata_c;
   assign bus.mem_en    = mem_en_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_addr  = mem_addr_c;
   assign bus.mem_wdata = mem_wdata_c;
   assign bus.mem_be    = mem_be_c;

   assign busy      = (state_q == ST_WAIT);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table on a
// latency-2 instance, then reset-mid-access and latency-1 sequences.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m2 ();
   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1 ();
   logic       busy2, busy1;
   arb_state_t st2, st1;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_MAX(4)) u2 (
      .clk(clk), .rst_n(rst_n), .bus(m2), .busy(busy2), .state_dbg(st2));
   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_MAX(4)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(m1), .busy(busy1), .state_dbg(st1));

   // ---------------- memory model ----------------
   function automatic logic [31:0] data_of(input logic [31:0] a);
      return 32'hDEADBEEF + (a - 32'h40);
   endfunction

   logic [31:0] m2_a1, m2_a2, m1_a1;
   always @(posedge clk) begin
      m2_a1 <= m2.mem_addr;
      m2_a2 <= m2_a1;
      m1_a1 <= m1.mem_addr;
   end
   assign m2.mem_rdata = data_of(m2_a2);
   assign m1.mem_rdata = data_of(m1_a1);

   // ---------------- scoreboard ----------------
   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic        if_req;
      logic [31:0] if_addr;
      logic        if_flush;
      logic        dm_req;
      logic        dm_we;
      logic [31:0] dm_addr;
      logic [31:0] dm_wdata;
      logic [BE_W-1:0] dm_be;
      logic        e_if_gnt;
      logic        e_dm_gnt;
      logic        e_if_rv;
      logic        e_dm_rv;
      logic        e_mem_en;
      logic        e_mem_we;
      logic [31:0] e_mem_addr;
      logic [31:0] e_mem_wdata;
      logic [BE_W-1:0] e_mem_be;
      logic [31:0] e_if_rdata;
      logic [31:0] e_dm_rdata;
      logic        e_busy;
   } vec_t;

   vec_t vecs[$];
   vec_t cur;

   task automatic v_in(input logic ifr, input logic [31:0] ifa, input logic ifl,
                       input logic dmr, input logic dmwe, input logic [31:0] dma,
                       input logic [31:0] dmwd, input logic [BE_W-1:0] dmbe, input logic bsy);
      cur = '0;
      cur.if_req = ifr; cur.if_addr = ifa; cur.if_flush = ifl;
      cur.dm_req = dmr; cur.dm_we = dmwe; cur.dm_addr = dma;
      cur.dm_wdata = dmwd; cur.dm_be = dmbe; cur.e_busy = bsy;
   endtask

   task automatic v_gif(input logic [31:0] a);
      cur.e_if_gnt = 1'b1; cur.e_mem_en = 1'b1; cur.e_mem_addr = a; cur.e_mem_be = '1;
   endtask

   task automatic v_gdm(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [BE_W-1:0] be);
      cur.e_dm_gnt = 1'b1; cur.e_mem_en = 1'b1; cur.e_mem_we = we;
      cur.e_mem_addr = a; cur.e_mem_wdata = wd; cur.e_mem_be = be;
   endtask

   task automatic v_rif(input logic [31:0] a);
      cur.e_if_rv = 1'b1; cur.e_if_rdata = data_of(a);
   endtask

   task automatic v_rdm(input logic [31:0] a, input logic store);
      cur.e_dm_rv = 1'b1; cur.e_dm_rdata = store ? 32'h0 : data_of(a);
   endtask

   task automatic v_push();
      vecs.push_back(cur);
   endtask

   task automatic drive2(input vec_t v);
      m2.if_req = v.if_req; m2.if_addr = v.if_addr; m2.if_flush = v.if_flush;
      m2.dm_req = v.dm_req; m2.dm_we = v.dm_we; m2.dm_addr = v.dm_addr;
      m2.dm_wdata = v.dm_wdata; m2.dm_be = v.dm_be;
   endtask

   task automatic check2(input int i, input vec_t v);
      chk($sformatf("v%0d if_gnt", i),    m2.if_gnt,    v.e_if_gnt);
      chk($sformatf("v%0d dm_gnt", i),    m2.dm_gnt,    v.e_dm_gnt);
      chk($sformatf("v%0d if_rvalid", i), m2.if_rvalid, v.e_if_rv);
      chk($sformatf("v%0d dm_rvalid", i), m2.dm_rvalid, v.e_dm_rv);
      chk($sformatf("v%0d mem_en", i),    m2.mem_en,    v.e_mem_en);
      chk($sformatf("v%0d mem_we", i),    m2.mem_we,    v.e_mem_we);
      chk($sformatf("v%0d mem_addr", i),  m2.mem_addr,  v.e_mem_addr);
      chk($sformatf("v%0d mem_wdata", i), m2.mem_wdata, v.e_mem_wdata);
      chk($sformatf("v%0d mem_be", i),    m2.mem_be,    v.e_mem_be);
      chk($sformatf("v%0d if_rdata", i),  m2.if_rdata,  v.e_if_rdata);
      chk($sformatf("v%0d dm_rdata", i),  m2.dm_rdata,  v.e_dm_rdata);
      chk($sformatf("v%0d busy", i),      busy2,        v.e_busy);
   endtask

   task automatic idle_inputs();
      m2.if_req = 0; m2.if_addr = 0; m2.if_flush = 0; m2.dm_req = 0; m2.dm_we = 0;
      m2.dm_addr = 0; m2.dm_wdata = 0; m2.dm_be = 0;
      m1.if_req = 0; m1.if_addr = 0; m1.if_flush = 0; m1.dm_req = 0; m1.dm_we = 0;
      m1.dm_addr = 0; m1.dm_wdata = 0; m1.dm_be = 0;
   endtask

   // ---------------- test ----------------
   initial begin
      // single load at 0x40
      v_in(0,0,0, 1,0,32'h40,0,4'hF, 0); v_gdm(0,32'h40,0,4'hF); v_push();
      v_in(0,0,0, 0,0,0,0,0, 1); v_push();
      v_in(0,0,0, 0,0,0,0,0, 1); v_rdm(32'h40,0); v_push();
      v_in(0,0,0, 0,0,0,0,0, 0); v_push();
      // store: be 0011, wdata 0x1234; response data must be 0
      v_in(0,0,0, 1,1,32'h80,32'h1234,4'b0011, 0); v_gdm(1,32'h80,32'h1234,4'b0011); v_push();
      v_in(0,0,0, 0,0,0,0,0, 1); v_push();
      v_in(0,0,0, 0,0,0,0,0, 1); v_rdm(32'h80,1); v_push();
      v_in(0,0,0, 0,0,0,0,0, 0); v_push();
      // fetch held against a stream of loads: DM,DM,DM,DM,IF,DM
      v_in(1,32'h100,0, 1,0,32'h200,0,4'hF, 0); v_gdm(0,32'h200,0,4'hF); v_push();
      v_in(1,32'h100,0, 1,0,32'h204,0,4'hF, 1); v_push();
      v_in(1,32'h100,0, 1,0,32'h204,0,4'hF, 1); v_rdm(32'h200,0); v_gdm(0,32'h204,0,4'hF); v_push();
      v_in(1,32'h100,0, 1,0,32'h208,0,4'hF, 1); v_push();
      v_in(1,32'h100,0, 1,0,32'h208,0,4'hF, 1); v_rdm(32'h204,0); v_gdm(0,32'h208,0,4'hF); v_push();
      v_in(1,32'h100,0, 1,0,32'h20C,0,4'hF, 1); v_push();
      v_in(1,32'h100,0, 1,0,32'h20C,0,4'hF, 1); v_rdm(32'h208,0); v_gdm(0,32'h20C,0,4'hF); v_push();
      v_in(1,32'h100,0, 1,0,32'h210,0,4'hF, 1); v_push();
      v_in(1,32'h100,0, 1,0,32'h210,0,4'hF, 1); v_rdm(32'h20C,0); v_gif(32'h100); v_push();
      v_in(1,32'h104,0, 1,0,32'h210,0,4'hF, 1); v_push();
      v_in(1,32'h104,0, 1,0,32'h210,0,4'hF, 1); v_rif(32'h100); v_gdm(0,32'h210,0,4'hF); v_push();
      v_in(0,0,0, 0,0,0,0,0, 1); v_push();
      v_in(0,0,0, 0,0,0,0,0, 1); v_rdm(32'h210,0); v_push();
      v_in(0,0,0, 0,0,0,0,0, 0); v_push();
      // flush one cycle after an IF grant; pending load issues at completion
      v_in(1,32'h300,0, 0,0,0,0,0, 0); v_gif(32'h300); v_push();
      v_in(0,0,1, 0,0,0,0,0, 1); v_push();
      v_in(0,0,0, 1,0,32'h400,0,4'hF, 1); v_gdm(0,32'h400,0,4'hF); v_push();
      v_in(0,0,0, 0,0,0,0,0, 1); v_push();
      v_in(0,0,0, 0,0,0,0,0, 1); v_rdm(32'h400,0); v_push();
      v_in(0,0,0, 0,0,0,0,0, 0); v_push();
      // flush on the completion cycle itself; masked fetch is not granted
      v_in(1,32'h500,0, 0,0,0,0,0, 0); v_gif(32'h500); v_push();
      v_in(0,0,0, 0,0,0,0,0, 1); v_push();
      v_in(1,32'h504,1, 0,0,0,0,0, 1); v_push();
      v_in(0,0,0, 0,0,0,0,0, 0); v_push();
      // flush while idle masks the fetch request
      v_in(1,32'h600,1, 0,0,0,0,0, 0); v_push();
      v_in(0,0,0, 0,0,0,0,0, 0); v_push();

      // reset state
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk("rst if_gnt", m2.if_gnt, 0);
      chk("rst dm_rvalid", m2.dm_rvalid, 0);
      chk("rst mem_en", m2.mem_en, 0);
      chk("rst busy", busy2, 0);
      chk("rst state", 32'(st2), 32'(ST_IDLE));
      @(negedge clk);
      rst_n = 1'b1;

      // table-driven section
      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk); #1;
         drive2(vecs[i]);
         @(negedge clk);
         check2(i, vecs[i]);
      end

      // reset in the middle of a fetch
      @(posedge clk); #1;
      idle_inputs();
      m2.if_req = 1; m2.if_addr = 32'h700;
      @(negedge clk);
      chk("mid fetch if_gnt", m2.if_gnt, 1);
      @(posedge clk); #1;
      m2.if_req = 0; m2.dm_req = 1; m2.dm_addr = 32'h780; m2.dm_be = 4'hF;
      chk("mid busy before rst", busy2, 1);
      #2; rst_n = 1'b0; #1;
      chk("mid rst dm_gnt", m2.dm_gnt, 0);
      chk("mid rst mem_en", m2.mem_en, 0);
      chk("mid rst mem_addr", m2.mem_addr, 0);
      chk("mid rst mem_be", m2.mem_be, 0);
      chk("mid rst if_rvalid", m2.if_rvalid, 0);
      chk("mid rst busy", busy2, 0);
      chk("mid rst state", 32'(st2), 32'(ST_IDLE));
      @(negedge clk);
      m2.dm_req = 0;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("post rst if_rvalid c%0d", k), m2.if_rvalid, 0);
         chk($sformatf("post rst busy c%0d", k), busy2, 0);
      end
      @(posedge clk); #1;
      m2.dm_req = 1; m2.dm_addr = 32'h784;
      @(negedge clk);
      chk("post rst dm_gnt", m2.dm_gnt, 1);
      chk("post rst busy at grant", busy2, 0);
      @(posedge clk); #1;
      m2.dm_req = 0;
      @(negedge clk);
      chk("post rst busy in flight", busy2, 1);
      @(negedge clk);
      chk("post rst dm_rvalid", m2.dm_rvalid, 1);
      chk("post rst dm_rdata", m2.dm_rdata, data_of(32'h784));

      // latency-1 instance: alternating IF/DM, one grant + one response per cycle
      for (int k = 0; k <= 6; k++) begin
         logic [31:0] a;
         logic [31:0] e;
         @(posedge clk); #1;
         m1.if_req = 0; m1.dm_req = 0;
         a = (k % 2 == 0) ? 32'h800 + 32'(4 * k) : 32'h900 + 32'(4 * k);
         if (k < 6) begin
            if (k % 2 == 0) begin
               m1.if_req = 1; m1.if_addr = a;
            end else begin
               m1.dm_req = 1; m1.dm_addr = a; m1.dm_be = 4'hF;
            end
         end
         @(negedge clk);
         chk($sformatf("l1 c%0d if_gnt", k), m1.if_gnt, (k < 6) && (k % 2 == 0));
         chk($sformatf("l1 c%0d dm_gnt", k), m1.dm_gnt, (k < 6) && (k % 2 == 1));
         chk($sformatf("l1 c%0d busy", k), busy1, k > 0);
         if (k > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("l1 c%0d if_rvalid", k), m1.if_rvalid, (k - 1) % 2 == 0);
            chk($sformatf("l1 c%0d dm_rvalid", k), m1.dm_rvalid, (k - 1) % 2 == 1);
            if ((k - 1) % 2 == 0) chk($sformatf("l1 c%0d if_rdata", k), m1.if_rdata, e);
            else chk($sformatf("l1 c%0d dm_rdata", k), m1.dm_rdata, e);
         end
         if (k < 6) exp_q.push_back(data_of(a));
      end
      @(negedge clk);
      chk("l1 idle busy", busy1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
